// File: rtl/lcd_spi_rx_decoder.sv
// Passive LCD SPI bus listener: rebuilds bytes from SCL/CS/DC/MOSI and
// decodes command, parameter index and RAMWR pixel/frame progress.
module lcd_spi_rx_decoder #(
  parameter int FRAME_BYTES = 25600,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCL,
  input  logic        CS,
  input  logic        DC,
  input  logic        MOSI,
  output logic        BYTE_VALID,
  output logic [7:0]  BYTE_DATA,
  output logic        BYTE_IS_CMD,
  output logic [7:0]  CMD,
  output logic [7:0]  PARAM_IDX,
  output logic        RAMWR_ACTIVE,
  output logic [14:0] PIX_BYTE_CNT,
  output logic        FRAME_DONE,
  output logic [7:0]  FRAME_COUNT,
  output logic        FRAG_ERR
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [14:0] PIX_LAST = 15'(FRAME_BYTES - 1);
  localparam logic [7:0] RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    EMIT
  } state_t;

  logic [NS-1:0] scl_q, cs_q, dc_q, mosi_q;
  logic          scl_s, cs_s, dc_s, mosi_s;
  logic          scl_d, scl_rise;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          byte_dc;
  logic          shift_en, last_bit, frag, emit;

  // Bus lines preset to their idle levels so reset creates no edges
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_q  <= '1;
      cs_q   <= '1;
      dc_q   <= '1;
      mosi_q <= '1;
      scl_d  <= 1'b1;
    end else begin
      scl_q  <= {scl_q[NS-2:0], SCL};
      cs_q   <= {cs_q[NS-2:0], CS};
      dc_q   <= {dc_q[NS-2:0], DC};
      mosi_q <= {mosi_q[NS-2:0], MOSI};
      scl_d  <= scl_s;
    end
  end

  assign scl_s    = scl_q[NS-1];
  assign cs_s     = cs_q[NS-1];
  assign dc_s     = dc_q[NS-1];
  assign mosi_s   = mosi_q[NS-1];
  assign scl_rise = scl_s & ~scl_d & ~cs_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    frag      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_s) state_nxt = RECV;
      end
      RECV: begin
        if (cs_s) begin
          state_nxt = IDLE;
          frag      = (bit_cnt != 3'd0);
        end else if (scl_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            last_bit  = 1'b1;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        state_nxt = cs_s ? IDLE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign emit = (state == EMIT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      byte_dc <= 1'b0;
    end else begin
      if (shift_en) begin
        bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
        shreg   <= {shreg[6:0], mosi_s};
      end else if (state != RECV) begin
        bit_cnt <= 3'd0;
      end
      if (last_bit) byte_dc <= dc_s;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BYTE_VALID   <= 1'b0;
      BYTE_DATA    <= 8'h00;
      BYTE_IS_CMD  <= 1'b0;
      CMD          <= 8'h00;
      PARAM_IDX    <= 8'h00;
      RAMWR_ACTIVE <= 1'b0;
      PIX_BYTE_CNT <= 15'd0;
      FRAME_DONE   <= 1'b0;
      FRAME_COUNT  <= 8'h00;
      FRAG_ERR     <= 1'b0;
    end else begin
      BYTE_VALID <= emit;
      FRAG_ERR   <= frag;
      FRAME_DONE <= 1'b0;
      if (emit) begin
        BYTE_DATA   <= shreg;
        BYTE_IS_CMD <= ~byte_dc;
        if (!byte_dc) begin
          CMD          <= shreg;
          PARAM_IDX    <= 8'h00;
          RAMWR_ACTIVE <= (shreg == RAMWR);
          if (shreg == RAMWR) PIX_BYTE_CNT <= 15'd0;
        end else begin
          if (PARAM_IDX != 8'hFF) PARAM_IDX <= PARAM_IDX + 8'd1;
          if (RAMWR_ACTIVE) begin
            if (PIX_BYTE_CNT == PIX_LAST) begin
              PIX_BYTE_CNT <= 15'd0;
              FRAME_DONE   <= 1'b1;
              FRAME_COUNT  <= FRAME_COUNT + 8'd1;
            end else begin
              PIX_BYTE_CNT <= PIX_BYTE_CNT + 15'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// Bench for lcd_spi_rx_decoder: drives the LCD bus at SCL=CLK/4 and
// checks decoded bytes against a byte-level reference model.
module tb_lcd_spi_rx_decoder;

  localparam int FB = 64;
  localparam int NS = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SCL = 1'b1;
  logic        CS = 1'b1;
  logic        DC = 1'b1;
  logic        MOSI = 1'b1;
  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_IS_CMD;
  logic [7:0]  CMD;
  logic [7:0]  PARAM_IDX;
  logic        RAMWR_ACTIVE;
  logic [14:0] PIX_BYTE_CNT;
  logic        FRAME_DONE;
  logic [7:0]  FRAME_COUNT;
  logic        FRAG_ERR;

  lcd_spi_rx_decoder #(
    .FRAME_BYTES(FB),
    .SYNC_STAGES(NS)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SCL(SCL),
    .CS(CS),
    .DC(DC),
    .MOSI(MOSI),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_DATA(BYTE_DATA),
    .BYTE_IS_CMD(BYTE_IS_CMD),
    .CMD(CMD),
    .PARAM_IDX(PARAM_IDX),
    .RAMWR_ACTIVE(RAMWR_ACTIVE),
    .PIX_BYTE_CNT(PIX_BYTE_CNT),
    .FRAME_DONE(FRAME_DONE),
    .FRAME_COUNT(FRAME_COUNT),
    .FRAG_ERR(FRAG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  data;
    logic        is_cmd;
    logic [7:0]  cmd;
    logic [7:0]  pidx;
    logic        ramwr;
    logic [14:0] pix;
    logic        fdone;
    logic [7:0]  fcnt;
  } ev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frag_cnt = 0;
  int fd_cnt = 0;
  int both_cnt = 0;

  ev_t ev_q[$];
  ev_t exp_q[$];
  int  evc_q[$];
  int  edge_q[$];

  // Reference model state, byte level
  logic [7:0] m_cmd;
  int         m_pidx;
  bit         m_ram;
  int         m_pix;
  int         m_frames;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST) begin
      if (BYTE_VALID) begin
        ev_q.push_back({BYTE_DATA, BYTE_IS_CMD, CMD, PARAM_IDX,
                        RAMWR_ACTIVE, PIX_BYTE_CNT, FRAME_DONE,
                        FRAME_COUNT});
        evc_q.push_back(cyc);
      end
      if (FRAG_ERR) frag_cnt <= frag_cnt + 1;
      if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
      if (FRAG_ERR && BYTE_VALID) both_cnt <= both_cnt + 1;
    end
  end

  function automatic void model_reset();
    m_cmd    = 8'h00;
    m_pidx   = 0;
    m_ram    = 1'b0;
    m_pix    = 0;
    m_frames = 0;
  endfunction

  function automatic ev_t model_byte(logic [7:0] b, logic dc);
    ev_t e;
    bit fd;
    fd = 1'b0;
    if (!dc) begin
      m_cmd  = b;
      m_pidx = 0;
      m_ram  = (b == 8'h2C);
      if (m_ram) m_pix = 0;
    end else begin
      m_pidx = (m_pidx + 1 > 255) ? 255 : m_pidx + 1;
      if (m_ram) begin
        m_pix = m_pix + 1;
        if (m_pix == FB) begin
          m_pix    = 0;
          fd       = 1'b1;
          m_frames = (m_frames + 1) % 256;
        end
      end
    end
    e.data   = b;
    e.is_cmd = ~dc;
    e.cmd    = m_cmd;
    e.pidx   = 8'(m_pidx);
    e.ramwr  = m_ram;
    e.pix    = 15'(m_pix);
    e.fdone  = fd;
    e.fcnt   = 8'(m_frames);
    return e;
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_q();
    ev_q.delete();
    exp_q.delete();
    evc_q.delete();
    edge_q.delete();
  endtask

  task automatic get_ev(output ev_t a, output ev_t e,
                        output int lat, output bit have);
    have = (ev_q.size() > 0) && (exp_q.size() > 0);
    a = '0;
    e = '0;
    lat = -1;
    if (have) begin
      a   = ev_q.pop_front();
      e   = exp_q.pop_front();
      lat = evc_q.pop_front() - edge_q.pop_front();
    end
  endtask

  // DC is scrambled during the first seven bits; only the 8th counts
  task automatic send_byte(input logic [7:0] b, input logic dc,
                           input bit rel);
    if (CS) begin
      CS = 1'b0;
      clk_n(4);
    end
    for (int i = 7; i >= 0; i--) begin
      MOSI = b[i];
      DC   = (i == 0) ? dc : 1'($urandom);
      SCL  = 1'b0;
      clk_n(2);
      SCL = 1'b1;
      if (i == 0) edge_q.push_back(cyc);
      clk_n(2);
    end
    exp_q.push_back(model_byte(b, dc));
    if (rel) begin
      CS = 1'b1;
      clk_n(6);
    end
  endtask

  task automatic test_reset();
    logic [51:0] outs;
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      SCL  = 1'($urandom);
      CS   = 1'($urandom);
      DC   = 1'($urandom);
      MOSI = 1'($urandom);
      clk_n(1);
    end
    outs = {BYTE_VALID, BYTE_DATA, BYTE_IS_CMD, CMD, PARAM_IDX,
            RAMWR_ACTIVE, PIX_BYTE_CNT, FRAME_DONE, FRAME_COUNT,
            FRAG_ERR};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_hold: outs=%h want 0", outs);
    end
    SCL = 1'b1;
    CS  = 1'b1;
    DC  = 1'b1;
    MOSI = 1'b1;
    clk_n(2);
    RST = 1'b1;
    model_reset();
    clk_n(10);
    outs = {BYTE_VALID, BYTE_DATA, BYTE_IS_CMD, CMD, PARAM_IDX,
            RAMWR_ACTIVE, PIX_BYTE_CNT, FRAME_DONE, FRAME_COUNT,
            FRAG_ERR};
    checks++;
    if (outs !== '0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release: outs=%h ev=%0d want 0",
               outs, ev_q.size());
    end
    clear_q();
  endtask

  task automatic test_cmd_param();
    ev_t a, e;
    int lat;
    bit have;
    clear_q();
    send_byte(8'h36, 1'b0, 1'b0);
    send_byte(8'hC8, 1'b1, 1'b1);
    clk_n(4);
    checks++;
    if (ev_q.size() != 2) begin
      errors++;
      $display("FAIL cp_count: got %0d want 2", ev_q.size());
    end
    get_ev(a, e, lat, have);
    checks++;
    if (!have || a.data !== 8'h36 || a.is_cmd !== 1'b1) begin
      errors++;
      $display("FAIL cp_byte0: got %h/%b want 36/1", a.data, a.is_cmd);
    end
    checks++;
    if (lat != NS + 2) begin
      errors++;
      $display("FAIL cp_lat0: got %0d want %0d", lat, NS + 2);
    end
    get_ev(a, e, lat, have);
    checks++;
    if (!have || a.data !== 8'hC8 || a.is_cmd !== 1'b0) begin
      errors++;
      $display("FAIL cp_byte1: got %h/%b want c8/0", a.data, a.is_cmd);
    end
    checks++;
    if (lat != NS + 2) begin
      errors++;
      $display("FAIL cp_lat1: got %0d want %0d", lat, NS + 2);
    end
    checks++;
    if (CMD !== 8'h36 || PARAM_IDX !== 8'd1 || RAMWR_ACTIVE !== 1'b0) begin
      errors++;
      $display("FAIL cp_decode: cmd=%h idx=%0d ram=%b want 36/1/0",
               CMD, PARAM_IDX, RAMWR_ACTIVE);
    end
  endtask

  task automatic test_fragment();
    ev_t a, e;
    int lat;
    int f0;
    bit have;
    clear_q();
    f0 = frag_cnt;
    CS = 1'b0;
    clk_n(4);
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'($urandom);
      SCL  = 1'b0;
      clk_n(2);
      SCL = 1'b1;
      clk_n(2);
    end
    CS = 1'b1;
    clk_n(8);
    checks++;
    if (frag_cnt - f0 != 1 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL frag_pulse: frags=%0d bytes=%0d want 1/0",
               frag_cnt - f0, ev_q.size());
    end
    send_byte(8'hB1, 1'b1, 1'b1);
    get_ev(a, e, lat, have);
    checks++;
    if (!have || a !== e || a.data !== 8'hB1) begin
      errors++;
      $display("FAIL frag_next: got %h want %h", a, e);
    end
  endtask

  task automatic test_frame();
    ev_t a, e;
    int lat, fd0, fd_idx, bad;
    bit have;
    clear_q();
    fd0 = fd_cnt;
    send_byte(8'h2C, 1'b0, 1'b0);
    for (int i = 0; i < FB; i++) send_byte(8'hFF, 1'b1, i == FB - 1);
    fd_idx = -1;
    bad = 0;
    for (int k = 0; k <= FB; k++) begin
      get_ev(a, e, lat, have);
      if (!have || a !== e) bad++;
      if (have && a.fdone) fd_idx = k;
    end
    checks++;
    if (fd_cnt - fd0 != 1 || fd_idx != FB) begin
      errors++;
      $display("FAIL frame_done: pulses=%0d at=%0d want 1 at %0d",
               fd_cnt - fd0, fd_idx, FB);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_events: %0d bad want 0", bad);
    end
    checks++;
    if (FRAME_COUNT !== 8'd1 || PIX_BYTE_CNT !== 15'd0) begin
      errors++;
      $display("FAIL frame_after: fc=%0d pix=%0d want 1/0",
               FRAME_COUNT, PIX_BYTE_CNT);
    end
    send_byte(8'hFF, 1'b1, 1'b1);
    checks++;
    if (PIX_BYTE_CNT !== 15'd1) begin
      errors++;
      $display("FAIL frame_extra: pix=%0d want 1", PIX_BYTE_CNT);
    end
    clear_q();
  endtask

  task automatic test_ramwr_exit();
    clear_q();
    send_byte(8'h2C, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'h2A, 1'b0, 1'b1);
    checks++;
    if (RAMWR_ACTIVE !== 1'b0 || PIX_BYTE_CNT !== 15'd10 ||
        CMD !== 8'h2A) begin
      errors++;
      $display("FAIL ramwr_exit: ram=%b pix=%0d cmd=%h want 0/10/2a",
               RAMWR_ACTIVE, PIX_BYTE_CNT, CMD);
    end
    for (int i = 0; i < 300; i++)
      send_byte(8'($urandom), 1'b1, i == 299);
    checks++;
    if (PARAM_IDX !== 8'd255 || PIX_BYTE_CNT !== 15'd10) begin
      errors++;
      $display("FAIL param_sat: idx=%0d pix=%0d want 255/10",
               PARAM_IDX, PIX_BYTE_CNT);
    end
    clear_q();
  endtask

  task automatic test_reset_mid_byte();
    logic [51:0] outs;
    ev_t a, e;
    int lat;
    bit have;
    clear_q();
    CS = 1'b0;
    clk_n(4);
    for (int i = 7; i >= 4; i--) begin
      MOSI = 8'hA5 >> i;
      SCL  = 1'b0;
      clk_n(2);
      SCL = 1'b1;
      clk_n(2);
    end
    RST = 1'b0;
    #1;
    outs = {BYTE_VALID, BYTE_DATA, BYTE_IS_CMD, CMD, PARAM_IDX,
            RAMWR_ACTIVE, PIX_BYTE_CNT, FRAME_DONE, FRAME_COUNT,
            FRAG_ERR};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rst_async: outs=%h want 0", outs);
    end
    CS = 1'b1;
    clk_n(3);
    RST = 1'b1;
    model_reset();
    clk_n(6);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL rst_nobyte: bytes=%0d want 0", ev_q.size());
    end
    send_byte(8'h5A, 1'b0, 1'b1);
    get_ev(a, e, lat, have);
    checks++;
    if (!have || a !== e || BYTE_DATA !== 8'h5A) begin
      errors++;
      $display("FAIL rst_resume: got %h data=%h want %h",
               a, BYTE_DATA, e);
    end
  endtask

  task automatic test_random(input string tag, input int n,
                             input bit hold);
    ev_t a, e;
    int lat, bad, b0, bc;
    bit have;
    logic [7:0] b;
    logic dc;
    clear_q();
    b0 = both_cnt;
    for (int i = 0; i < n; i++) begin
      dc = ($urandom_range(3) != 0);
      b  = 8'($urandom);
      if (!dc && $urandom_range(2) == 0) b = 8'h2C;
      send_byte(b, dc, (i == n - 1) || (!hold && $urandom_range(3) == 0));
    end
    bad = 0;
    bc = exp_q.size();
    for (int k = 0; k < bc; k++) begin
      get_ev(a, e, lat, have);
      if (!have || a !== e || lat != NS + 2) begin
        bad++;
        if (bad < 4)
          $display("FAIL %s_ev%0d: got %h lat %0d want %h", tag, k,
                   a, lat, e);
      end
    end
    checks++;
    if (bad != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bad, %0d extra want 0/0", tag, bad,
               ev_q.size());
    end
    checks++;
    if (both_cnt != b0) begin
      errors++;
      $display("FAIL %s_exclusive: %0d overlaps want 0", tag,
               both_cnt - b0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cmd_param();
    test_fragment();
    test_frame();
    test_ramwr_exit();
    test_random("back_to_back", 120, 1'b1);
    test_reset_mid_byte();
    test_random("random", 200, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
